t01_piece_scheduler: RTL and testbench
======================================

# t01_piece_scheduler

Sequences falling pieces for the team_01 Tetris core. It draws base piece types from a 7-bag randomizer and keeps a one-piece preview. It also runs the rotation handshake with the collision checker and drives `current_block_type` into the block-pattern generator. It sits between the game-control FSM and the blockgen/collision datapath.

## Interface
- `LFSR_SEED`, default 16'hACE1: reset value of the randomizer LFSR. A value of 0 is replaced by 16'h0001.
- `ROT_TIMEOUT`, default 4: cycles to wait in ROT_WAIT for `rot_ok`/`rot_fail` before treating the rotation as failed (range 1-15).
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous and active-high.
- `spawn_req` in 1: game FSM requests a new falling piece.
- `lock` in 1: the current piece has landed; the piece is no longer live.
- `rotate_req` in 1: rotate the current piece clockwise.
- `rot_ok` in 1: collision checker accepts `cand_type`.
- `rot_fail` in 1: collision checker rejects `cand_type`.
- `hold_req` in 1: swap with the hold slot. Present only with `T01_HOLD_EN`.
- `current_block_type` out 5: type code of the live piece, fed to blockgen.
- `next_block_type` out 5: preview piece, always a base type 0-6 after prime.
- `hold_block_type` out 5: held base type, 5'h1F when empty. Present only with `T01_HOLD_EN`.
- `cand_type` out 5: proposed rotated type, fed to the second blockgen instance.
- `cand_valid` out 1: `cand_type` is awaiting a verdict.
- `spawn_valid` out 1: one-cycle pulse when `current_block_type` takes a new spawned piece.
- `rot_done` out 1: one-cycle pulse when a rotation is committed.
- `busy` out 1: the FSM is not in IDLE.

## Operation
- Type codes: base types are I=0, O=1, S=2, Z=3, L=4, J=5, T=6. 5'h1F means "no piece" and blockgen renders it as blank.
- Clockwise rotation cycles:
  - I: 0→7→0
  - O: 1→1
  - S: 2→8→2
  - Z: 3→9→3
  - L: 4→10→11→12→4
  - J: 5→13→14→15→5
  - T: 6→16→17→18→6
- `base_of()` maps any code 0-18 back to its base type.
- LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1, shifts every cycle after reset.
- Draw is single-cycle and combinational:
  - Take r = `lfsr[2:0]`; if r is 7, use 0.
  - Pick the first base type at index ≥ r (mod 7) whose `bag_mask` bit is clear, and set that bit.
  - If the mask becomes 7'h7F, clear it to 0 in the same cycle (bag refill).
- FSM states: PRIME, IDLE, ROT_WAIT.
- PRIME, entered on reset: one draw into `next_block_type`, then go to IDLE.
- IDLE, priority spawn > hold > rotate. Other requests in the same cycle are dropped.
  - `spawn_req`: current ← next, next ← draw, piece_live ← 1, hold_used ← 0, pulse `spawn_valid`.
  - `lock`: piece_live ← 0. Lock has priority over a rotate in the same cycle.
  - `rotate_req` while piece_live: cand_type ← rot_next(current), `cand_valid` ← 1, go to ROT_WAIT, load the timeout counter.
  - `rotate_req` while not live: ignored.
- ROT_WAIT:
  - `rot_ok` alone: current ← cand_type, pulse `rot_done`.
  - `rot_fail`, both `rot_ok` and `rot_fail` asserted, or timeout expiry: current is unchanged.
  - In every exit case: `cand_valid` ← 0, go to IDLE.
  - `spawn_req`, `hold_req`, `rotate_req` and `lock` are ignored in this state. The game FSM must gate them with `busy`.
- Rotating an O piece still runs the full handshake.
- Reset values:
  - `current_block_type` = `next_block_type` = `cand_type` = 5'h1F.
  - `hold_block_type` = 5'h1F.
  - All pulse outputs and `cand_valid` = 0.
  - `busy` = 1 (PRIME). `bag_mask` = 0, piece_live = 0, lfsr = `LFSR_SEED`.
- A reset asserted mid-ROT_WAIT abandons the candidate and restarts at PRIME.

## Timing
- All outputs are registered.
- Spawn: `spawn_req` sampled in cycle N → new current/next and `spawn_valid` visible in N+1.
- Rotate: `rotate_req` in N → `cand_valid` high in N+1.
  - A verdict sampled in cycle M commits in M+1 (`rot_done`, new current, `cand_valid` low).
  - Fastest round trip: the verdict arrives in N+1 and the commit is visible in N+2.
- Timeout: with no verdict, `cand_valid` is high for exactly `ROT_TIMEOUT` cycles, then deasserts and `busy` drops.
- PRIME lasts exactly 1 cycle after `rst` deasserts.

## Configuration
- `T01_HOLD_EN` defined:
  - `hold_req` in IDLE with piece_live and !hold_used swaps current with hold, sets hold_used, and takes 1 cycle.
  - The hold slot stores `base_of(current)`.
  - A piece swapped out of hold enters at its base orientation.
  - If the hold slot is empty: current ← next, next ← draw.
  - `spawn_valid` does not pulse on a hold.
  - A second hold before the next spawn is ignored.
- `T01_HOLD_EN` undefined: no hold ports, no hold register, no hold_used logic.

## Structure
- Package `t01_tetris_pkg` holds:
  - base-type constants I..T and NO_PIECE = 5'h1F;
  - the `rot_next()` and `base_of()` functions;
  - the FSM state enum.
- The same package is shared with blockgen and the collision checker.
- One sub-module, `t01_bag7`: LFSR, `bag_mask`, draw logic, a `draw` strobe in and a `draw_type` out.

## Test plan
- Reset, then release:
  - In the first cycle `busy`=1 and current=next=5'h1F.
  - One cycle later `busy`=0 and next ∈ 0-6.
- 14 spawns spaced 2 cycles apart: spawns 1-7 and spawns 8-14 each contain every type 0-6 exactly once.
- Rotation commit on an L piece:
  - Spawn until current=4, then rotate with `rot_ok` one cycle after `cand_valid` rises.
  - current goes 4→10; three more rotations give 11, 12, 4.
  - `rot_done` pulses once per rotation.
- Rotation failure and timeout, with current=6:
  - `rot_fail` → current stays 6.
  - No verdict → `cand_valid` high for 4 cycles, current stays 6, no `rot_done`.
  - `rot_ok` and `rot_fail` in the same cycle → current stays 6.
- Request conflicts:
  - `spawn_req` and `rotate_req` in the same cycle → spawn only, `cand_valid` stays 0.
  - `rotate_req` after `lock` → ignored.
  - `rst` during ROT_WAIT → `cand_valid`=0 and current=5'h1F next cycle.
- Hold, with `T01_HOLD_EN`, current=16:
  - First hold → hold=6 and current = previous next.
  - Second hold → ignored.
  - Spawn, then hold → current=6.

Source files
------------

// File: rtl/t01_tetris_pkg.sv
// rtl/t01_tetris_pkg.sv - shared piece type codes, rotation tables and scheduler state enum
package t01_tetris_pkg;

  localparam logic [4:0] TYPE_I   = 5'd0;
  localparam logic [4:0] TYPE_O   = 5'd1;
  localparam logic [4:0] TYPE_S   = 5'd2;
  localparam logic [4:0] TYPE_Z   = 5'd3;
  localparam logic [4:0] TYPE_L   = 5'd4;
  localparam logic [4:0] TYPE_J   = 5'd5;
  localparam logic [4:0] TYPE_T   = 5'd6;
  localparam logic [4:0] NO_PIECE = 5'h1F;

  typedef enum logic [1:0] {
    ST_PRIME    = 2'd0,
    ST_IDLE     = 2'd1,
    ST_ROT_WAIT = 2'd2
  } state_t;

  // Clockwise successor; codes 7-18 are the non-base orientations.
  function automatic logic [4:0] rot_next(input logic [4:0] t);
    logic [4:0] r;
    case (t)
      5'd0:    r = 5'd7;
      5'd7:    r = 5'd0;
      5'd1:    r = 5'd1;
      5'd2:    r = 5'd8;
      5'd8:    r = 5'd2;
      5'd3:    r = 5'd9;
      5'd9:    r = 5'd3;
      5'd4:    r = 5'd10;
      5'd10:   r = 5'd11;
      5'd11:   r = 5'd12;
      5'd12:   r = 5'd4;
      5'd5:    r = 5'd13;
      5'd13:   r = 5'd14;
      5'd14:   r = 5'd15;
      5'd15:   r = 5'd5;
      5'd6:    r = 5'd16;
      5'd16:   r = 5'd17;
      5'd17:   r = 5'd18;
      5'd18:   r = 5'd6;
      default: r = NO_PIECE;
    endcase
    return r;
  endfunction

  function automatic logic [4:0] base_of(input logic [4:0] t);
    logic [4:0] r;
    case (t)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6: r = t;
      5'd7:                r = TYPE_I;
      5'd8:                r = TYPE_S;
      5'd9:                r = TYPE_Z;
      5'd10, 5'd11, 5'd12: r = TYPE_L;
      5'd13, 5'd14, 5'd15: r = TYPE_J;
      5'd16, 5'd17, 5'd18: r = TYPE_T;
      default:             r = NO_PIECE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/t01_bag7.sv
// rtl/t01_bag7.sv - 7-bag randomizer: free-running LFSR plus bag mask, single-cycle combinational draw
module t01_bag7
  import t01_tetris_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       draw,
  output logic [4:0] draw_type
);

  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  logic [15:0] lfsr;
  logic [6:0]  bag_mask;
  logic [6:0]  mask_set;
  logic [6:0]  mask_next;
  logic [2:0]  start;
  logic [2:0]  pick;
  logic [3:0]  idx;
  logic        found;
  logic        feedback;

  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1.
  assign feedback = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  always_comb begin
    start = (lfsr[2:0] == 3'd7) ? 3'd0 : lfsr[2:0];
    pick  = start;
    found = 1'b0;
    idx   = 4'd0;
    for (int k = 0; k < 7; k++) begin
      idx = {1'b0, start} + 4'(k);
      if (idx >= 4'd7) idx = idx - 4'd7;
      if (!found && !bag_mask[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    mask_set  = bag_mask | (7'd1 << pick);
    mask_next = (mask_set == 7'h7F) ? 7'h00 : mask_set;
    draw_type = {2'b00, pick};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr     <= SEED;
      bag_mask <= 7'h00;
    end else begin
      lfsr <= {feedback, lfsr[15:1]};
      if (draw) bag_mask <= mask_next;
    end
  end

endmodule

// File: rtl/t01_piece_scheduler.sv
// rtl/t01_piece_scheduler.sv - piece sequencer, preview and rotation handshake; hold slot under T01_HOLD_EN
module t01_piece_scheduler
  import t01_tetris_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          ROT_TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spawn_req,
  input  logic       lock,
  input  logic       rotate_req,
  input  logic       rot_ok,
  input  logic       rot_fail,
`ifdef T01_HOLD_EN
  input  logic       hold_req,
  output logic [4:0] hold_block_type,
`endif
  output logic [4:0] current_block_type,
  output logic [4:0] next_block_type,
  output logic [4:0] cand_type,
  output logic       cand_valid,
  output logic       spawn_valid,
  output logic       rot_done,
  output logic       busy
);

  localparam logic [3:0] TIMEOUT_LOAD = 4'(ROT_TIMEOUT);

  state_t     state, state_n;
  logic [4:0] cur_n, nxt_n, cand_n;
  logic       cv_n, sv_n, rd_n, busy_n;
  logic       live, live_n;
  logic [3:0] timer, timer_n;
  logic       draw;
  logic       rot_exit;
  logic [4:0] draw_type;
`ifdef T01_HOLD_EN
  logic [4:0] hold_n;
  logic       hold_used, used_n;
`endif

  t01_bag7 #(.LFSR_SEED(LFSR_SEED)) u_bag7 (
    .clk       (clk),
    .rst       (rst),
    .draw      (draw),
    .draw_type (draw_type)
  );

  always_comb begin
    state_n  = state;
    cur_n    = current_block_type;
    nxt_n    = next_block_type;
    cand_n   = cand_type;
    cv_n     = cand_valid;
    sv_n     = 1'b0;
    rd_n     = 1'b0;
    live_n   = live;
    timer_n  = timer;
    draw     = 1'b0;
    rot_exit = 1'b0;
`ifdef T01_HOLD_EN
    hold_n   = hold_block_type;
    used_n   = hold_used;
`endif
    case (state)
      ST_PRIME: begin
        nxt_n   = draw_type;
        draw    = 1'b1;
        state_n = ST_IDLE;
      end
      ST_IDLE: begin
        if (spawn_req) begin
          cur_n  = next_block_type;
          nxt_n  = draw_type;
          draw   = 1'b1;
          live_n = 1'b1;
          sv_n   = 1'b1;
`ifdef T01_HOLD_EN
          used_n = 1'b0;
`endif
        end else if (lock) begin
          live_n = 1'b0;
`ifdef T01_HOLD_EN
        end else if (hold_req && live && !hold_used) begin
          // Held pieces always come back in their base orientation.
          hold_n = base_of(current_block_type);
          used_n = 1'b1;
          if (hold_block_type == NO_PIECE) begin
            cur_n = next_block_type;
            nxt_n = draw_type;
            draw  = 1'b1;
          end else begin
            cur_n = hold_block_type;
          end
`endif
        end else if (rotate_req && live) begin
          cand_n  = rot_next(current_block_type);
          cv_n    = 1'b1;
          timer_n = TIMEOUT_LOAD;
          state_n = ST_ROT_WAIT;
        end
      end
      ST_ROT_WAIT: begin
        if (rot_ok && !rot_fail) begin
          cur_n    = cand_type;
          rd_n     = 1'b1;
          rot_exit = 1'b1;
        end else if (rot_fail || timer <= 4'd1) begin
          rot_exit = 1'b1;
        end else begin
          timer_n = timer - 4'd1;
        end
        if (rot_exit) begin
          cv_n    = 1'b0;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_PRIME;
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= ST_PRIME;
      current_block_type <= NO_PIECE;
      next_block_type    <= NO_PIECE;
      cand_type          <= NO_PIECE;
      cand_valid         <= 1'b0;
      spawn_valid        <= 1'b0;
      rot_done           <= 1'b0;
      busy               <= 1'b1;
      live               <= 1'b0;
      timer              <= 4'd0;
`ifdef T01_HOLD_EN
      hold_block_type    <= NO_PIECE;
      hold_used          <= 1'b0;
`endif
    end else begin
      state              <= state_n;
      current_block_type <= cur_n;
      next_block_type    <= nxt_n;
      cand_type          <= cand_n;
      cand_valid         <= cv_n;
      spawn_valid        <= sv_n;
      rot_done           <= rd_n;
      busy               <= busy_n;
      live               <= live_n;
      timer              <= timer_n;
`ifdef T01_HOLD_EN
      hold_block_type    <= hold_n;
      hold_used          <= used_n;
`endif
    end
  end

endmodule

// File: tb/tb_t01_piece_scheduler.sv
// tb/tb_t01_piece_scheduler.sv - scoreboard bench for the piece scheduler
module tb_t01_piece_scheduler;
  import t01_tetris_pkg::*;

  localparam int ROT_TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spawn_req = 1'b0, lock = 1'b0, rotate_req = 1'b0, rot_ok = 1'b0, rot_fail = 1'b0;
`ifdef T01_HOLD_EN
  logic       hold_req = 1'b0;
  logic [4:0] hold_block_type;
`endif
  logic [4:0] current_block_type, next_block_type, cand_type;
  logic       cand_valid, spawn_valid, rot_done, busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit         is_rot;
    logic [4:0] cur;
  } ev_t;

  ev_t        exp_q[$];
  logic [4:0] spawned[$];
  ev_t        mon_e;

  always #5 clk = ~clk;

  t01_piece_scheduler #(.LFSR_SEED(16'hACE1), .ROT_TIMEOUT(ROT_TIMEOUT)) dut (
    .clk                (clk),
    .rst                (rst),
    .spawn_req          (spawn_req),
    .lock               (lock),
    .rotate_req         (rotate_req),
    .rot_ok             (rot_ok),
    .rot_fail           (rot_fail),
`ifdef T01_HOLD_EN
    .hold_req           (hold_req),
    .hold_block_type    (hold_block_type),
`endif
    .current_block_type (current_block_type),
    .next_block_type    (next_block_type),
    .cand_type          (cand_type),
    .cand_valid         (cand_valid),
    .spawn_valid        (spawn_valid),
    .rot_done           (rot_done),
    .busy               (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every spawn_valid / rot_done pulse must match the next queued event.
  always @(negedge clk) begin
    if (!rst && (spawn_valid || rot_done)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {30'd0, spawn_valid, rot_done}, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("event_is_rot", rot_done, mon_e.is_rot);
        chk("event_is_spawn", spawn_valid, !mon_e.is_rot);
        if (mon_e.is_rot) begin
          chk("rot_current", current_block_type, mon_e.cur);
        end else begin
          chk("spawn_current_base", current_block_type < 5'd7, 1);
          chk("spawn_next_base", next_block_type < 5'd7, 1);
          spawned.push_back(current_block_type);
        end
      end
    end
  end

  task automatic spawn();
    exp_q.push_back('{1'b0, NO_PIECE});
    spawn_req = 1'b1;
    step();
    spawn_req = 1'b0;
    step();
  endtask

  task automatic spawn_until(input logic [4:0] target);
    for (int i = 0; i < 14; i++) begin
      if (current_block_type == target) break;
      spawn();
    end
    chk("reach_type", current_block_type, target);
  endtask

  // mode: 0 rot_ok, 1 rot_fail, 2 both, 3 no verdict
  task automatic rotate(input logic [4:0] exp_cand, input int mode, input logic [4:0] exp_cur);
    int n;
    rotate_req = 1'b1;
    step();
    rotate_req = 1'b0;
    chk("cand_valid_rise", cand_valid, 1);
    chk("cand_type", cand_type, exp_cand);
    chk("busy_in_rot_wait", busy, 1);
    if (mode == 3) begin
      n = 0;
      while (cand_valid && n < 20) begin
        n++;
        step();
      end
      chk("timeout_cand_valid_cycles", n, ROT_TIMEOUT);
    end else begin
      step();
      if (mode == 0) exp_q.push_back('{1'b1, exp_cur});
      rot_ok   = (mode != 1);
      rot_fail = (mode != 0);
      step();
      rot_ok   = 1'b0;
      rot_fail = 1'b0;
    end
    chk("cand_valid_fall", cand_valid, 0);
    chk("current_after_rot", current_block_type, exp_cur);
    chk("busy_after_rot", busy, 0);
  endtask

  initial begin
    logic [6:0] mask;
    logic [4:0] prev_next;

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("reset_busy", busy, 1);
    chk("reset_current", current_block_type, 5'h1F);
    chk("reset_next", next_block_type, 5'h1F);
    chk("reset_cand_type", cand_type, 5'h1F);
    chk("reset_cand_valid", cand_valid, 0);
    chk("reset_spawn_valid", spawn_valid, 0);
    chk("reset_rot_done", rot_done, 0);
`ifdef T01_HOLD_EN
    chk("reset_hold", hold_block_type, 5'h1F);
`endif
    step();
    chk("prime_busy", busy, 0);
    chk("prime_next_base", next_block_type < 5'd7, 1);
    chk("prime_current", current_block_type, 5'h1F);

    for (int i = 0; i < 14; i++) spawn();
    chk("spawn_count", spawned.size(), 14);
    for (int g = 0; g < 2; g++) begin
      mask = 7'h00;
      for (int i = 0; i < 7; i++)
        if (spawned.size() > g * 7 + i && spawned[g*7+i] < 5'd7)
          mask = mask | (7'd1 << spawned[g*7+i][2:0]);
      chk("bag_complete", mask, 7'h7F);
    end

    spawn_until(TYPE_L);
    rotate(5'd10, 0, 5'd10);
    rotate(5'd11, 0, 5'd11);
    rotate(5'd12, 0, 5'd12);
    rotate(5'd4,  0, 5'd4);

    spawn_until(TYPE_T);
    rotate(5'd16, 1, 5'd6);
    rotate(5'd16, 3, 5'd6);
    rotate(5'd16, 2, 5'd6);

    exp_q.push_back('{1'b0, NO_PIECE});
    spawn_req  = 1'b1;
    rotate_req = 1'b1;
    step();
    spawn_req  = 1'b0;
    rotate_req = 1'b0;
    chk("spawn_rotate_conflict_cand_valid", cand_valid, 0);
    chk("spawn_rotate_conflict_busy", busy, 0);
    step();

    lock = 1'b1;
    step();
    lock = 1'b0;
    rotate_req = 1'b1;
    step();
    rotate_req = 1'b0;
    chk("rotate_after_lock_cand_valid", cand_valid, 0);
    chk("rotate_after_lock_busy", busy, 0);
    step();

    spawn();
    rotate_req = 1'b1;
    step();
    rotate_req = 1'b0;
    chk("pre_reset_cand_valid", cand_valid, 1);
    rst = 1'b1;
    step();
    chk("mid_rot_reset_cand_valid", cand_valid, 0);
    chk("mid_rot_reset_current", current_block_type, 5'h1F);
    chk("mid_rot_reset_busy", busy, 1);
    rst = 1'b0;
    step();
    chk("post_reset_busy", busy, 0);

`ifdef T01_HOLD_EN
    spawn_until(TYPE_T);
    rotate(5'd16, 0, 5'd16);
    prev_next = next_block_type;
    hold_req = 1'b1;
    step();
    hold_req = 1'b0;
    chk("hold_first_slot", hold_block_type, 5'd6);
    chk("hold_first_current", current_block_type, prev_next);
    chk("hold_no_spawn_valid", spawn_valid, 0);
    hold_req = 1'b1;
    step();
    hold_req = 1'b0;
    chk("hold_second_slot", hold_block_type, 5'd6);
    chk("hold_second_current", current_block_type, prev_next);
    spawn();
    hold_req = 1'b1;
    step();
    hold_req = 1'b0;
    chk("hold_swap_back_current", current_block_type, 5'd6);
`else
    prev_next = 5'h1F;
    if (prev_next == 5'h00) $display("unused");
`endif

    step();
    step();
    chk("events_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
